// File: rtl/systolic_data_setup_unit_pkg.sv
// Shared types and constants for the systolic array front end.
// The array, the accumulator and the data setup unit all use the same tile geometry.
package systolic_data_setup_unit_pkg;

    localparam int ARRAY_DIM     = 32;
    localparam int DATA_W        = 8;
    localparam int UB_RD_LAT_DEF = 1;

    typedef logic [ARRAY_DIM-1:0][DATA_W-1:0] array_row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } setup_state_t;

    // Drain counter has to hold the full post-feed flush length.
    function automatic int drain_cnt_w(input int dim, input int lat);
        return $clog2(dim + lat + 1);
    endfunction

endpackage

// File: rtl/systolic_data_setup_unit_if.sv
// Unified-buffer read side and systolic-array feed side of the data setup unit.
// master = tile sequencer / testbench side, slave = the setup unit itself.
interface systolic_data_setup_unit_if #(
    parameter int ARRAY_DIM = systolic_data_setup_unit_pkg::ARRAY_DIM,
    parameter int DATA_W    = systolic_data_setup_unit_pkg::DATA_W
);

    logic                          unified_buffer_read_en_i;
    logic [ARRAY_DIM*DATA_W-1:0]   unified_buffer_data_i;
    logic [ARRAY_DIM*DATA_W-1:0]   array_data_o;
    logic [ARRAY_DIM-1:0]          array_valid_o;
    logic                          busy_o;
    logic                          drain_done_o;

    modport master (
        output unified_buffer_read_en_i,
        output unified_buffer_data_i,
        input  array_data_o,
        input  array_valid_o,
        input  busy_o,
        input  drain_done_o
    );

    modport slave (
        input  unified_buffer_read_en_i,
        input  unified_buffer_data_i,
        output array_data_o,
        output array_valid_o,
        output busy_o,
        output drain_done_o
    );

endinterface

// File: rtl/systolic_data_setup_unit_skew_delay_line.sv
// One lane of the skew: DEPTH registers of data+valid, data forced to zero when invalid.
// DEPTH=0 is a wire so lane 0 sees stage 0 directly.
module systolic_data_setup_unit_skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk_i, rst_i};
            assign vld_o = vld_i;
            assign dat_o = vld_i ? dat_i : '0;
        end else begin : g_delay
            logic [DEPTH-1:0] vld_q;
            logic [DEPTH-1:0] vld_d;
            logic [WIDTH-1:0] dat_q [DEPTH];
            logic [WIDTH-1:0] dat_d [DEPTH];

            always_comb begin
                vld_d    = '0;
                vld_d[0] = vld_i;
                dat_d[0] = vld_i ? dat_i : '0;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_q[i] <= dat_d[i];
                    end
                end
            end

            assign vld_o = vld_q[DEPTH-1];
            assign dat_o = dat_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_data_setup_unit.sv
// Turns unified-buffer read rows into a diagonal wavefront for the systolic array:
// tracks read latency, skews lane k by k cycles, and reports busy / drain completion.
module systolic_data_setup_unit #(
    parameter int ARRAY_DIM     = systolic_data_setup_unit_pkg::ARRAY_DIM,
    parameter int DATA_W        = systolic_data_setup_unit_pkg::DATA_W,
    parameter int UB_RD_LATENCY = systolic_data_setup_unit_pkg::UB_RD_LAT_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    systolic_data_setup_unit_if.slave   ub_arr
);

    import systolic_data_setup_unit_pkg::*;

    localparam int ROW_W = ARRAY_DIM * DATA_W;
    localparam int CNT_W = drain_cnt_w(ARRAY_DIM, UB_RD_LATENCY);
    // Stage 0 plus ARRAY_DIM-1 skew registers: the last lane clears ARRAY_DIM-1
    // cycles after the feed state sees an empty latency pipe.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY_DIM - 2);

    // Read-latency tracking
    logic [UB_RD_LATENCY-1:0] lat_q;
    logic [UB_RD_LATENCY-1:0] lat_d;
    logic                     v_cap;
    logic                     lat_any;

    generate
        if (UB_RD_LATENCY == 1) begin : g_lat1
            assign lat_d = ub_arr.unified_buffer_read_en_i;
        end else begin : g_latn
            assign lat_d = {lat_q[UB_RD_LATENCY-2:0], ub_arr.unified_buffer_read_en_i};
        end
    endgenerate

    assign v_cap   = lat_q[UB_RD_LATENCY-1];
    assign lat_any = |lat_q;

    // Stage 0 capture
    logic             s0_vld_q;
    logic             s0_vld_d;
    logic [ROW_W-1:0] s0_dat_q;
    logic [ROW_W-1:0] s0_dat_d;

    assign s0_vld_d = v_cap;
    assign s0_dat_d = v_cap ? ub_arr.unified_buffer_data_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_q    <= '0;
            s0_vld_q <= 1'b0;
            s0_dat_q <= '0;
        end else begin
            lat_q    <= lat_d;
            s0_vld_q <= s0_vld_d;
            s0_dat_q <= s0_dat_d;
        end
    end

    // Per-lane skew
    logic [ARRAY_DIM-1:0] lane_vld;
    logic [ROW_W-1:0]     lane_dat;

    generate
        for (genvar k = 0; k < ARRAY_DIM; k++) begin : g_lane
            systolic_data_setup_unit_skew_delay_line #(
                .DEPTH (k),
                .WIDTH (DATA_W)
            ) u_skew (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .vld_i (s0_vld_q),
                .dat_i (s0_dat_q[k*DATA_W +: DATA_W]),
                .vld_o (lane_vld[k]),
                .dat_o (lane_dat[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign ub_arr.array_valid_o = lane_vld;
    assign ub_arr.array_data_o  = lane_dat;

    // Sequencing FSM
    setup_state_t     state_q;
    setup_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lat_any) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (!lat_any && !v_cap) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // A fresh strobe wins over completion; the drain restarts later.
                if (lat_any) begin
                    state_d = FEED;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The latency pipe term covers the first cycle, before the FSM leaves IDLE.
    assign ub_arr.busy_o       = (state_q != IDLE) || lat_any;
    assign ub_arr.drain_done_o = done_q;

endmodule

// File: tb/tb_systolic_data_setup_unit.sv
// Bench for the data setup unit: two instances (read latency 1 and 3) on a 4x8 geometry,
// checked every cycle against a strobe-history model plus literal expectations.
module tb_systolic_data_setup_unit;

    import systolic_data_setup_unit_pkg::*;

    localparam int DIM  = 4;
    localparam int DW   = 8;
    localparam int RW   = DIM * DW;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit            strb    [MAXC];
    logic [RW-1:0] row_mem [MAXC];

    int n_assert = 0;
    int n_fail   = 0;

    systolic_data_setup_unit_if #(.ARRAY_DIM(DIM), .DATA_W(DW)) bus1 ();
    systolic_data_setup_unit_if #(.ARRAY_DIM(DIM), .DATA_W(DW)) bus3 ();

    systolic_data_setup_unit #(.ARRAY_DIM(DIM), .DATA_W(DW), .UB_RD_LATENCY(1)) u_dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .ub_arr (bus1)
    );

    systolic_data_setup_unit #(.ARRAY_DIM(DIM), .DATA_W(DW), .UB_RD_LATENCY(3)) u_dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .ub_arr (bus3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit strobe_at(input int t);
        return (t >= 0 && t < MAXC) ? strb[t] : 1'b0;
    endfunction

    // Model: lane k at cycle c shows the row read at c-L-1-k; busy covers [t+1, t+L+DIM]
    // for every strobe t; drain done fires at t+L+DIM+1 when no later strobe reached the FSM in time.
    task automatic check_dut(input int lat, input string tag, input logic [RW-1:0] dat,
                             input logic [DIM-1:0] vld, input logic busy, input logic done);
        logic [RW-1:0]  ed;
        logic [DIM-1:0] ev;
        logic           eb;
        logic           edn;
        int             c;
        int             t0;
        ed = '0;
        ev = '0;
        eb = 1'b0;
        edn = 1'b0;
        c = cyc;
        for (int k = 0; k < DIM; k++) begin
            if (strobe_at(c - lat - 1 - k)) begin
                ev[k] = 1'b1;
                ed[k*DW +: DW] = row_mem[c - lat - 1 - k][k*DW +: DW];
            end
        end
        for (int t = c - lat - DIM; t <= c - 1; t++) begin
            if (strobe_at(t)) eb = 1'b1;
        end
        t0 = c - lat - DIM - 1;
        if (strobe_at(t0)) begin
            edn = 1'b1;
            for (int t = t0 + 1; t <= c - 2; t++) begin
                if (strobe_at(t)) edn = 1'b0;
            end
        end
        chk({tag, "_valid"}, 64'(vld),  64'(ev));
        chk({tag, "_data"},  64'(dat),  64'(ed));
        chk({tag, "_busy"},  64'(busy), 64'(eb));
        chk({tag, "_done"},  64'(done), 64'(edn));
    endtask

    always @(negedge clk) begin
        check_dut(1, "l1", bus1.array_data_o, bus1.array_valid_o, bus1.busy_o, bus1.drain_done_o);
        check_dut(3, "l3", bus3.array_data_o, bus3.array_valid_o, bus3.busy_o, bus3.drain_done_o);
    end

    // Unified buffer stand-in: data appears L cycles after its strobe, garbage otherwise.
    task automatic drive(input bit en, input logic [RW-1:0] r);
        @(posedge clk);
        #1;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        strb[cyc]    = en;
        row_mem[cyc] = r;
        bus1.unified_buffer_read_en_i = en;
        bus3.unified_buffer_read_en_i = en;
        bus1.unified_buffer_data_i = strobe_at(cyc - 1) ? row_mem[cyc - 1] : RW'($urandom);
        bus3.unified_buffer_data_i = strobe_at(cyc - 3) ? row_mem[cyc - 3] : RW'($urandom);
    endtask

    task automatic idle_collect(input int n, output int first1, output int cnt1,
                                output int first3, output int cnt3, output int busy_low1);
        first1 = -1; cnt1 = 0; first3 = -1; cnt3 = 0; busy_low1 = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0);
            @(negedge clk);
            if (bus1.drain_done_o === 1'b1) begin
                if (first1 < 0) first1 = cyc;
                cnt1++;
            end
            if (bus3.drain_done_o === 1'b1) begin
                if (first3 < 0) first3 = cyc;
                cnt3++;
            end
            if (bus1.busy_o !== 1'b1) busy_low1++;
        end
    endtask

    int T, f1, c1, f3, c3, bl;

    initial begin
        bus1.unified_buffer_read_en_i = 1'b0;
        bus1.unified_buffer_data_i    = '0;
        bus3.unified_buffer_read_en_i = 1'b0;
        bus3.unified_buffer_data_i    = '0;
        repeat (3) drive(1'b0, '0);
        @(negedge clk);
        chk("reset_valid", 64'(bus1.array_valid_o), 64'd0);
        chk("reset_busy",  64'(bus1.busy_o),        64'd0);
        chk("reset_done",  64'(bus3.drain_done_o),  64'd0);
        drive(1'b0, '0);
        #1 rst = 1'b0;
        repeat (5) drive(1'b0, '0);

        // Single strobe, row {04,03,02,01}
        drive(1'b1, 32'h04030201);
        T = cyc;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, '0);
            @(negedge clk);
            case (i)
                1: chk("single_busy_t1", 64'(bus1.busy_o), 64'd1);
                2: begin
                    chk("single_l1_lane0_vld", 64'(bus1.array_valid_o), 64'h1);
                    chk("single_l1_lane0_dat", 64'(bus1.array_data_o),  64'h00000001);
                end
                4: chk("single_l3_lane0_dat", 64'(bus3.array_data_o), 64'h00000001);
                5: begin
                    chk("single_l1_lane3_vld", 64'(bus1.array_valid_o), 64'h8);
                    chk("single_l1_lane3_dat", 64'(bus1.array_data_o),  64'h04000000);
                    chk("single_l3_lane1_dat", 64'(bus3.array_data_o),  64'h00000200);
                end
                6: begin
                    chk("single_l1_done_t6", 64'(bus1.drain_done_o), 64'd1);
                    chk("single_l1_busy_t6", 64'(bus1.busy_o),       64'd0);
                end
                7: begin
                    chk("single_l3_lane3_vld", 64'(bus3.array_valid_o), 64'h8);
                    chk("single_l1_done_t7",   64'(bus1.drain_done_o),  64'd0);
                end
                8: chk("single_l3_done_t8", 64'(bus3.drain_done_o), 64'd1);
                default: ;
            endcase
        end
        repeat (3) drive(1'b0, '0);

        // Four back-to-back strobes, lane0 = 1..4, lane3 = 0x11..0x14
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, {8'(16 + i), 16'h0000, 8'(i)});
            if (i == 1) T = cyc;
        end
        idle_collect(14, f1, c1, f3, c3, bl);
        chk("burst4_done_cycle", 64'(f1 - T), 64'd9);
        chk("burst4_done_count", 64'(c1),     64'd1);

        // Two bursts separated by one idle cycle
        drive(1'b1, 32'hA1A2A3A4);
        T = cyc;
        drive(1'b1, 32'hB1B2B3B4);
        drive(1'b0, '0);
        drive(1'b1, 32'hC1C2C3C4);
        drive(1'b1, 32'hD1D2D3D4);
        idle_collect(5, f1, c1, f3, c3, bl);
        chk("gap_busy_low", 64'(bl), 64'd0);
        chk("gap_no_early_done", 64'(c1), 64'd0);
        idle_collect(10, f1, c1, f3, c3, bl);
        chk("gap_done_cycle", 64'(f1 - T), 64'd10);
        chk("gap_done_count", 64'(c1),     64'd1);

        // Two isolated strobes ten cycles apart
        drive(1'b1, 32'h55667788);
        T = cyc;
        repeat (9) drive(1'b0, '0);
        drive(1'b1, 32'h99AABBCC);
        idle_collect(12, f1, c1, f3, c3, bl);
        chk("iso_done_count", 64'(c1), 64'd1);
        chk("iso_second_done", 64'(f1 - T), 64'd16);
        chk("iso_l3_second_done", 64'(f3 - T), 64'd18);

        // Asynchronous reset in the middle of a single strobe
        drive(1'b1, 32'h04030201);
        T = cyc;
        drive(1'b0, '0);
        drive(1'b0, '0);
        drive(1'b0, '0);
        #1 rst = 1'b1;
        for (int i = 0; i < MAXC; i++) strb[i] = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus1.array_valid_o), 64'd0);
        chk("rst_mid_data",  64'(bus1.array_data_o),  64'd0);
        chk("rst_mid_busy",  64'(bus1.busy_o),        64'd0);
        chk("rst_mid_fsm",   64'(u_dut1.state_q),     64'(IDLE));
        drive(1'b0, '0);
        #1 rst = 1'b0;
        idle_collect(12, f1, c1, f3, c3, bl);
        chk("rst_no_done_l1", 64'(c1), 64'd0);
        chk("rst_no_done_l3", 64'(c3), 64'd0);

        // Random bursts with random holes and gaps
        for (int b = 0; b < 60; b++) begin
            int len;
            int gap;
            len = $urandom_range(1, 7);
            gap = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                drive(($urandom_range(0, 4) != 0), RW'($urandom));
            end
            repeat (gap) drive(1'b0, '0);
        end
        repeat (12) drive(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d required finish", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
